// File: rtl/iter_shift_unit.sv
// Iterative one-bit-per-cycle shifter for the shll/shrl/shra instructions.
// The result goes back to the register-file write port, and busy stalls issue while a shift is running.
//
// state   | meaning
// S_IDLE  | waiting for start; inputs are sampled here only
// S_SHIFT | shifting the latched value by one bit per clock
// S_DONE  | result valid; done/control_RegWrite pulse for one cycle
module iter_shift_unit #(
  parameter int DATA_W     = 32,
  parameter int SHAMT_W    = 5,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            shift_op,
  input  logic [DATA_W-1:0]     operand,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     writeData,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic                  control_RegWrite
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [DATA_W-1:0]       sh_reg, sh_step;
  logic [SHAMT_W-1:0]      cnt;
  logic [1:0]              op;
  logic [REG_ADDR_W-1:0]   dst;
  logic                    accept;
  logic                    cnt_last;

  assign cnt_last = (cnt == SHAMT_W'(1));

  // Opcode 11 is reserved and behaves as a logical right shift.
  always_comb begin
    sh_step = sh_reg >> 1;
    case (op)
      2'b00:   sh_step = sh_reg << 1;
      2'b10:   sh_step = {sh_reg[DATA_W-1], sh_reg[DATA_W-1:1]};
      default: sh_step = sh_reg >> 1;
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_last) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy             = (state != S_IDLE);
  assign control_RegWrite = done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      writeData <= '0;
      writeReg  <= '0;
      sh_reg    <= '0;
      cnt       <= '0;
      op        <= '0;
      dst       <= '0;
    end else begin
      state <= state_next;
      // S_DONE lasts one cycle and always returns to S_IDLE, so this is a single pulse.
      done  <= (state_next == S_DONE);
      if (accept) begin
        sh_reg <= operand;
        op     <= shift_op;
        cnt    <= shamt;
        dst    <= dest_reg;
        if (shamt == '0) begin
          writeData <= operand;
          writeReg  <= dest_reg;
        end
      end else if (state == S_SHIFT) begin
        sh_reg <= sh_step;
        cnt    <= cnt - SHAMT_W'(1);
        if (cnt_last) begin
          writeData <= sh_step;
          writeReg  <= dst;
        end
      end
    end
  end

endmodule
